input_conditioner: RTL and testbench

Parametrised multi-channel front end for board buttons and switches: synchronizes, optionally inverts, debounces, and edge-detects `WIDTH` asynchronous inputs on the CPU clock. It replaces the separate synchronizer and button-parser instances between the board pins and the CPU/reset logic. It provides a debounced level, one-cycle press and release pulses per channel, and optional auto-repeat. All channels share one sample-tick timebase.

---
 rtl/input_conditioner.sv | 163 ++++++++++++++++
 tb/tb_input_conditioner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes, optionally inverts, debounces and edge-detects WIDTH async pins.
// Define INPUT_CONDITIONER_REPEAT_EN to add per-channel auto-repeat on press.
module input_conditioner #(
    parameter int               WIDTH          = 4,
    parameter int               SYNC_STAGES    = 2,
    parameter int               SAMPLE_CNT_MAX = 62500,
    parameter int               PULSE_CNT_MAX  = 200,
    parameter logic [WIDTH-1:0] INVERT         = '0,
    parameter int               REPEAT_DELAY   = 1000,
    parameter int               REPEAT_RATE    = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_pulse
);

    if (WIDTH < 1) begin : g_bad_width
        $error("input_conditioner: WIDTH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("input_conditioner: SYNC_STAGES must be >= 2");
    end
    if (SAMPLE_CNT_MAX < 1) begin : g_bad_sample
        $error("input_conditioner: SAMPLE_CNT_MAX must be >= 1");
    end
    if (PULSE_CNT_MAX < 1) begin : g_bad_pulse
        $error("input_conditioner: PULSE_CNT_MAX must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("input_conditioner: REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    localparam int TICK_W = $clog2(SAMPLE_CNT_MAX + 1);
    localparam int DB_W   = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(PULSE_CNT_MAX - 1);

    logic [WIDTH-1:0]  cond;
    logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  samp;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [DB_W-1:0]   db_cnt [WIDTH];
    logic [WIDTH-1:0]  flip;
    logic [WIDTH-1:0]  rpt_fire;

    // Inverted pins idle at conditioned 0, matching the reset value of the chain.
    assign cond = in ^ INVERT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= cond;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign samp = sync_q[SYNC_STAGES-1];

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // A channel flips on the tick that completes its run of disagreeing samples.
    always_comb begin
        flip = '0;
        for (int i = 0; i < WIDTH; i++) begin
            flip[i] = tick && (samp[i] != level[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            level <= level ^ flip;
            if (tick) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if ((samp[i] == level[i]) || flip[i]) begin
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

`ifdef INPUT_CONDITIONER_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    // rpt_rate | meaning
    //    0     | delay phase: waiting REPEAT_DELAY ticks after the press
    //    1     | rate phase: repeating every REPEAT_RATE ticks
    logic [RPT_W-1:0] rpt_cnt [WIDTH];
    logic [WIDTH-1:0] rpt_rate;

    always_comb begin
        rpt_fire = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rpt_fire[i] = tick && level[i] && !flip[i] &&
                          (rpt_cnt[i] == (rpt_rate[i] ? RPT_RATE_LAST : RPT_DELAY_LAST));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_rate <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                rpt_cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (flip[i] || !level[i] || rpt_fire[i]) begin
                    rpt_cnt[i] <= '0;
                end else begin
                    rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                end
                if (flip[i]) begin
                    rpt_rate[i] <= 1'b0;
                end else if (rpt_fire[i]) begin
                    rpt_rate[i] <= 1'b1;
                end
            end
        end
    end
`else
    assign rpt_fire = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press         <= '0;
            release_pulse <= '0;
        end else begin
            press         <= (flip & samp) | rpt_fire;
            release_pulse <= flip & ~samp;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Randomized and directed bench for input_conditioner, checked every cycle against a tick-level model.
module tb_input_conditioner;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int SM = 4;
    localparam int PM = 3;
    localparam int RD = 5;
    localparam int RR = 2;
    localparam logic [W-1:0] INV = 4'b1000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in;
    logic [W-1:0] level;
    logic [W-1:0] press;
    logic [W-1:0] release_pulse;

    always #5 clk = ~clk;

    input_conditioner #(
        .WIDTH(W), .SYNC_STAGES(SS), .SAMPLE_CNT_MAX(SM), .PULSE_CNT_MAX(PM),
        .INVERT(INV), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in),
        .level(level), .press(press), .release_pulse(release_pulse)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Model: pins reach the sampler SS cycles late; a level changes once PM consecutive
    // tick samples disagree with it; repeats land at D, D+R, D+2R... ticks after the rise.
    bit [W-1:0] m_level, m_press, m_rel, m_s;
    bit [W-1:0] m_hist[$];
    int         m_run[W];
    int         m_rise[W];
    int         m_edges, m_ticks, m_k;
    bit         m_tick, m_flip;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_level = '0;
            m_press = '0;
            m_rel   = '0;
            m_hist.delete();
            for (int k = 0; k < SS; k++) m_hist.push_back('0);
            m_edges = 0;
            m_ticks = 0;
            for (int c = 0; c < W; c++) begin
                m_run[c]  = 0;
                m_rise[c] = 0;
            end
        end else begin
            m_s = m_hist.pop_front();
            m_hist.push_back(in ^ INV);
            m_tick = ((m_edges % SM) == SM - 1);
            m_edges++;
            m_press = '0;
            m_rel   = '0;
            if (m_tick) begin
                m_ticks++;
                for (int c = 0; c < W; c++) begin
                    m_flip = 1'b0;
                    if (m_s[c] != m_level[c]) begin
                        m_run[c]++;
                        if (m_run[c] == PM) begin
                            m_flip     = 1'b1;
                            m_run[c]   = 0;
                            m_level[c] = m_s[c];
                            if (m_s[c]) begin
                                m_press[c] = 1'b1;
                                m_rise[c]  = m_ticks;
                            end else begin
                                m_rel[c] = 1'b1;
                            end
                        end
                    end else begin
                        m_run[c] = 0;
                    end
`ifdef INPUT_CONDITIONER_REPEAT_EN
                    if (!m_flip && m_level[c]) begin
                        m_k = m_ticks - m_rise[c];
                        if (m_k == RD || (m_k > RD && ((m_k - RD) % RR) == 0)) m_press[c] = 1'b1;
                    end
`endif
                end
            end
        end
    end

    always @(posedge clk) begin
        #3;
        chk("level", int'(level), int'(m_level));
        chk("press", int'(press), int'(m_press));
        chk("release", int'(release_pulse), int'(m_rel));
    end

    int first_press[W], npress[W], last_press[W], tot_press[W];
    int first_rel[W], nrel[W];
    int ptimes[$];
    int bounce_press;

    task automatic watch(input int ncyc);
        for (int c = 0; c < W; c++) begin
            first_press[c] = 0; npress[c] = 0; last_press[c] = 0;
            first_rel[c] = 0; nrel[c] = 0;
        end
        ptimes.delete();
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            for (int c = 0; c < W; c++) begin
                if (press[c]) begin
                    if (first_press[c] == 0) first_press[c] = n;
                    npress[c]++;
                    tot_press[c]++;
                    last_press[c] = n;
                    if (c == 0) ptimes.push_back(n);
                end
                if (release_pulse[c]) begin
                    if (first_rel[c] == 0) first_rel[c] = n;
                    nrel[c]++;
                end
            end
        end
    endtask

    initial begin
        for (int c = 0; c < W; c++) tot_press[c] = 0;
        rst_n = 1'b0;
        in    = 4'b1000;
        watch(3);
        chk("reset_level", int'(level), 0);
        chk("reset_press", int'(press), 0);
        chk("reset_release", int'(release_pulse), 0);
        rst_n = 1'b1;
        watch(10);

        // clean press on channel 0
        in[0] = 1'b1;
        watch(20);
        chk_rng("clean_press_latency", first_press[0], 11, 14);
        chk("clean_level0", int'(level[0]), 1);
        chk("clean_others_level", int'(level[3:1]), 0);
        chk("clean_others_press", npress[1] + npress[2] + npress[3], 0);

        // bounce on channel 1
        bounce_press = 0;
        for (int k = 0; k < 20; k++) begin
            in[1] = ~in[1];
            watch(3);
            bounce_press += npress[1];
        end
        chk("bounce_no_press", bounce_press, 0);
        in[1] = 1'b1;
        watch(14);
        chk("settle_press_count", npress[1], 1);
        chk("settle_level1", int'(level[1]), 1);

        // simultaneous release of channels 0 and 2
        in[2] = 1'b1;
        watch(20);
        chk("ch2_press_count", npress[2], 1);
        in[0] = 1'b0;
        in[2] = 1'b0;
        watch(20);
        chk("rel0_count", nrel[0], 1);
        chk("rel2_count", nrel[2], 1);
        chk("rel_same_cycle", first_rel[0], first_rel[2]);
        chk_rng("rel_latency", first_rel[0], 11, 14);
        chk("rel_no_press2", npress[2], 0);
        chk("rel_no_press0_after", (last_press[0] > first_rel[0]) ? 1 : 0, 0);
        chk("rel_levels", int'({level[2], level[0]}), 0);

        // long hold on channel 0: single press or auto-repeat
        in[0] = 1'b1;
        watch(70);
        chk_rng("hold_first_press", first_press[0], 11, 14);
`ifdef INPUT_CONDITIONER_REPEAT_EN
        chk_rng("repeat_count", npress[0], 3, 100);
        if (ptimes.size() >= 3) begin
            chk("repeat_delay_gap", ptimes[1] - ptimes[0], 20);
            chk("repeat_rate_gap", ptimes[2] - ptimes[1], 8);
        end
`else
        chk("no_repeat_count", npress[0], 1);
`endif
        in[0] = 1'b0;
        watch(30);
        chk("hold_release_count", nrel[0], 1);
        chk("hold_no_press_after", (last_press[0] > first_rel[0]) ? 1 : 0, 0);

        // inverted channel: no spurious press so far, then an active-low press
        chk("inv_no_spurious", tot_press[3], 0);
        in[3] = 1'b0;
        watch(20);
        chk_rng("inv_press_latency", first_press[3], 11, 14);
        chk("inv_level3", int'(level[3]), 1);

        // reset mid-qualification restarts from zero
        in = 4'b1000;
        watch(30);
        in = 4'b1100;
        watch(8);
        chk("midq_no_press", npress[2], 0);
        rst_n = 1'b0;
        #1;
        chk("midq_reset_level", int'(level), 0);
        chk("midq_reset_press", int'(press), 0);
        chk("midq_reset_release", int'(release_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        watch(20);
        chk("restart_latency", first_press[2], 12);

        // random stimulus, one reset in the middle
        for (int blk = 0; blk < 60; blk++) begin
            in = 4'($urandom_range(0, 15));
            if (blk == 30) begin
                rst_n = 1'b0;
                watch(2);
                rst_n = 1'b1;
            end
            watch($urandom_range(1, 30));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
